// File: rtl/spi_master_core.sv
// spi_master_core: parametrised SPI master engine.
// Takes TX words over a valid/ready handshake, shifts them out on mosi in any
// CPOL/CPHA mode and either bit order, and returns each received word as a
// one-cycle rx_valid pulse. The transaction config is latched at the accept.
module spi_master_core #(
    parameter int DW  = 8,
    parameter int SSW = 2,
    parameter int CDW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsbfirst,
    input  logic [CDW-1:0]      clkdiv,
    input  logic [3:0]          setup_cyc,
    input  logic [3:0]          hold_cyc,
    input  logic [SSW-1:0]      ss_sel,
    input  logic                tx_valid,
    input  logic [DW-1:0]       tx_data,
    input  logic                tx_last,
    output logic                tx_ready,
    output logic                rx_valid,
    output logic [DW-1:0]       rx_data,
    output logic                busy,
    output logic [1:0]          spi_state,
    output logic                sclk,
    output logic                mosi,
    output logic [(2**SSW)-1:0] ss_n,
    input  logic                miso
);

    localparam int NSS = 2 ** SSW;
    localparam int BW  = $clog2(DW);
    localparam logic [BW-1:0] LASTBIT = BW'(DW - 1);
    localparam logic [BW-1:0] ONE     = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        DATA  = 2'b10,
        HOLD  = 2'b11
    } stateT;

    stateT            r_state;
    stateT            w_nextState;

    logic [CDW-1:0]   r_div;
    logic [3:0]       r_cnt;
    logic [BW-1:0]    r_bit;
    logic             r_half;
    logic             r_wait;
    logic             r_gap;
    logic [DW-1:0]    r_txWord;
    logic [DW-1:0]    r_rxWord;
    logic [DW-1:0]    r_rxData;
    logic             r_rxValid;
    logic             r_last;
    logic             r_cpol;
    logic             r_cpha;
    logic             r_lsb;
    logic [CDW-1:0]   r_clkdiv;
    logic [3:0]       r_setup;
    logic [3:0]       r_hold;
    logic             r_sclk;
    logic             r_mosi;
    logic [NSS-1:0]   r_ssN;

    logic             w_txReady;
    logic             w_hs;
    logic             w_count;
    logic             w_tick;
    logic             w_half;
    logic [BW-1:0]    w_bit;
    logic [DW-1:0]    w_word;
    logic [BW-1:0]    w_idx;
    logic [BW-1:0]    w_idxNext;
    logic             w_dataActive;
    logic             w_setupDone;
    logic             w_holdDone;
    logic             w_lead;
    logic             w_trail;
    logic             w_wordEnd;
    logic [DW-1:0]    w_rxFinal;
    logic             w_firstBit;
    logic             w_mosi;

    // Handshake, half-period tick, edge decode and next-state selection.
    // While parked at a word boundary (r_wait) the bit/half position reads as
    // the start of a fresh word, so an accept and its first tick can coincide.
    always_comb begin
        w_nextState  = r_state;
        w_txReady    = !reset && (((r_state == IDLE) && !r_gap) ||
                                  ((r_state == DATA) && r_wait));
        w_hs         = tx_valid && w_txReady;
        w_count      = (r_state == IDLE) ? r_gap : !(r_wait && !tx_valid);
        w_tick       = w_count && (r_div == r_clkdiv);
        w_half       = r_wait ? 1'b0 : r_half;
        w_bit        = r_wait ? '0 : r_bit;
        w_word       = r_wait ? tx_data : r_txWord;
        w_idx        = r_lsb ? w_bit : (LASTBIT - w_bit);
        w_idxNext    = r_lsb ? (w_bit + ONE) : (LASTBIT - w_bit - ONE);
        w_dataActive = (r_state == DATA) && !(r_wait && !tx_valid);
        w_setupDone  = (r_state == SETUP) && w_tick && (r_cnt == r_setup);
        w_holdDone   = (r_state == HOLD) && w_tick && (r_cnt == r_hold);
        w_lead       = (w_tick && w_dataActive && !w_half) || w_setupDone;
        w_trail      = w_tick && w_dataActive && w_half;
        w_wordEnd    = w_trail && (w_bit == LASTBIT);
        w_rxFinal    = r_rxWord;
        w_rxFinal[w_idx] = miso;
        w_firstBit   = r_lsb ? tx_data[0] : tx_data[DW-1];
        w_mosi       = ((r_state == DATA) && r_wait && tx_valid && !r_cpha) ?
                       w_firstBit : r_mosi;
        case (r_state)
            IDLE:    if (w_hs)                  w_nextState = SETUP;
            SETUP:   if (w_setupDone)           w_nextState = DATA;
            DATA:    if (w_wordEnd && r_last)   w_nextState = HOLD;
            HOLD:    if (w_holdDone)            w_nextState = IDLE;
            default:                            w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Divider, counters, shift data, config latch and pad registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_half    <= 1'b0;
            r_wait    <= 1'b0;
            r_gap     <= 1'b0;
            r_txWord  <= '0;
            r_rxWord  <= '0;
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_last    <= 1'b0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_clkdiv  <= '0;
            r_setup   <= '0;
            r_hold    <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ssN     <= '1;
        end else begin
            r_rxValid <= 1'b0;

            if (w_count) begin
                r_div <= w_tick ? '0 : (r_div + CDW'(1));
            end else begin
                r_div <= '0;
            end

            if ((r_state == IDLE) && r_gap && w_tick) begin
                r_gap <= 1'b0;
            end

            if (w_hs && (r_state == IDLE)) begin
                r_txWord <= tx_data;
                r_last   <= tx_last;
                r_cpol   <= cpol;
                r_cpha   <= cpha;
                r_lsb    <= lsbfirst;
                r_clkdiv <= clkdiv;
                r_setup  <= setup_cyc;
                r_hold   <= hold_cyc;
                r_ssN    <= ~(NSS'(1) << ss_sel);
                r_sclk   <= cpol;
                r_cnt    <= '0;
                r_bit    <= '0;
                r_half   <= 1'b0;
                r_wait   <= 1'b0;
                if (!cpha) begin
                    r_mosi <= lsbfirst ? tx_data[0] : tx_data[DW-1];
                end
            end

            if (w_hs && (r_state == DATA)) begin
                r_txWord <= tx_data;
                r_last   <= tx_last;
                r_wait   <= 1'b0;
                r_bit    <= '0;
                r_half   <= 1'b0;
                if (!r_cpha) begin
                    r_mosi <= w_firstBit;
                end
            end

            if (((r_state == SETUP) || (r_state == HOLD)) && w_tick) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_setupDone) begin
                r_cnt <= '0;
            end
            if (w_holdDone) begin
                r_cnt <= '0;
                r_ssN <= '1;
                r_gap <= 1'b1;
            end

            if (w_lead) begin
                r_sclk <= ~r_cpol;
                r_half <= 1'b1;
                if (r_cpha) begin
                    r_mosi <= w_word[w_idx];
                end else begin
                    r_rxWord[w_idx] <= miso;
                end
            end

            if (w_trail) begin
                r_sclk <= r_cpol;
                r_half <= 1'b0;
                if (r_cpha) begin
                    r_rxWord[w_idx] <= miso;
                end
                if (w_wordEnd) begin
                    r_rxData  <= r_cpha ? w_rxFinal : r_rxWord;
                    r_rxValid <= 1'b1;
                    r_bit     <= '0;
                    r_cnt     <= '0;
                    if (!r_last) begin
                        r_wait <= 1'b1;
                    end
                end else begin
                    r_bit <= r_bit + ONE;
                    if (!r_cpha) begin
                        r_mosi <= r_txWord[w_idxNext];
                    end
                end
            end
        end
    end

    assign tx_ready  = w_txReady;
    assign rx_valid  = r_rxValid;
    assign rx_data   = r_rxData;
    assign busy      = (r_state != IDLE);
    assign spi_state = r_state;
    assign sclk      = (r_state == IDLE) ? cpol : r_sclk;
    assign mosi      = w_mosi;
    assign ss_n      = r_ssN;

endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: directed bench for spi_master_core with miso looped
// back to mosi, so every received word must equal the word that was sent.
module tb_spi_master_core;

   localparam int DW  = 8;
   localparam int SSW = 2;
   localparam int CDW = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic           lsbFirst = 1'b0;
   logic [CDW-1:0] clkDiv = 8'd1;
   logic [3:0]     setupCyc = 4'd0;
   logic [3:0]     holdCyc = 4'd0;
   logic [SSW-1:0] ssSel = 2'd2;
   logic           txValid = 1'b0;
   logic [DW-1:0]  txData = '0;
   logic           txLast = 1'b0;
   logic           txReady;
   logic           rxValid;
   logic [DW-1:0]  rxData;
   logic           busy;
   logic [1:0]     spiState;
   logic           sclk;
   logic           mosi;
   logic [3:0]     ssN;
   logic           miso;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int         edgeQ[$];
   logic       edgeValQ[$];
   logic       mosiQ[$];
   logic [3:0] ssQ[$];
   logic [7:0] rxQ[$];
   int         ssFallCyc, ssRiseCyc, readyRiseCyc, ssFallCount;
   logic       prevSclk, prevReady;
   logic [3:0] prevSs;
   logic [7:0] patt;

   assign miso = mosi;

   spi_master_core #(.DW(DW), .SSW(SSW), .CDW(CDW)) dut (
      .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsbfirst(lsbFirst),
      .clkdiv(clkDiv), .setup_cyc(setupCyc), .hold_cyc(holdCyc), .ss_sel(ssSel),
      .tx_valid(txValid), .tx_data(txData), .tx_last(txLast), .tx_ready(txReady),
      .rx_valid(rxValid), .rx_data(rxData), .busy(busy), .spi_state(spiState),
      .sclk(sclk), .mosi(mosi), .ss_n(ssN), .miso(miso)
   );

   // Core clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp observed events.
   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled on the inactive edge: sclk edges while selected,
   // select fall/rise times, tx_ready rise time and received words.
   always @(negedge clk) begin
      if (sclk !== prevSclk && ssN !== 4'hF) begin
         edgeQ.push_back(cyc);
         edgeValQ.push_back(sclk);
         mosiQ.push_back(mosi);
         ssQ.push_back(ssN);
      end
      prevSclk = sclk;
      if (ssN !== 4'hF && prevSs === 4'hF) begin
         ssFallCyc = cyc;
         ssFallCount++;
      end
      if (ssN === 4'hF && prevSs !== 4'hF) ssRiseCyc = cyc;
      prevSs = ssN;
      if (txReady && !prevReady) readyRiseCyc = cyc;
      prevReady = txReady;
      if (rxValid) rxQ.push_back(rxData);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearLog();
      edgeQ.delete();
      edgeValQ.delete();
      mosiQ.delete();
      ssQ.delete();
      rxQ.delete();
      ssFallCount = 0;
      ssFallCyc = 0;
      ssRiseCyc = 0;
      readyRiseCyc = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic last, input logic keep);
      int t = 0;
      @(negedge clk);
      txValid = 1'b1;
      txData = data;
      txLast = last;
      while (!txReady && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("txReadyWait", {31'b0, txReady}, 32'd1);
      @(posedge clk);
      #1;
      if (!keep) txValid = 1'b0;
   endtask

   task automatic waitIdle();
      int t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while (!(spiState == 2'b00 && txReady) && t < 3000);
      checkOutput("idleWait", {31'b0, (spiState == 2'b00 && txReady)}, 32'd1);
   endtask

   task automatic waitEdges(input int n);
      int t = 0;
      while (edgeQ.size() < n && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      checkOutput("edgeWait", {31'b0, (edgeQ.size() >= n)}, 32'd1);
   endtask

   task automatic waitRx(input int n);
      int t = 0;
      while (rxQ.size() < n && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      checkOutput("rxWait", rxQ.size(), n);
   endtask

   function automatic int badSpacing(input int want);
      int bad = 0;
      for (int i = 1; i < edgeQ.size(); i++)
         if (edgeQ[i] - edgeQ[i-1] != want) bad++;
      return bad;
   endfunction

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rstSsN", ssN, 4'hF);
      checkOutput("rstState", spiState, 2'b00);
      checkOutput("rstTxReady", txReady, 1'b0);
      checkOutput("rstRxValid", rxValid, 1'b0);
      checkOutput("rstRxData", rxData, 8'h00);
      checkOutput("rstMosi", mosi, 1'b0);
      checkOutput("rstBusy", busy, 1'b0);
      reset = 1'b0;
      #1;
      checkOutput("releaseTxReady", txReady, 1'b1);
      checkOutput("idleSclk", sclk, 1'b0);

      // Mode 0, MSB first, 0xA5, select 2, clkdiv 1.
      clearLog();
      applyStimulus(8'hA5, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      patt = 8'hA5;
      checkOutput("t1EdgeCount", edgeQ.size(), 16);
      checkOutput("t1Spacing", badSpacing(2), 0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("t1SsN", ssQ[2*i], 4'b1011);
         checkOutput("t1Mosi", mosiQ[2*i], patt[7-i]);
      end
      checkOutput("t1RxCount", rxQ.size(), 1);
      checkOutput("t1RxData", rxQ[0], 8'hA5);
      checkOutput("t1Gap", readyRiseCyc - ssRiseCyc, 2);

      // Mode 3, LSB first, back-to-back 0x3C then 0xC3.
      clearLog();
      cpol = 1'b1; cpha = 1'b1; lsbFirst = 1'b1; ssSel = 2'd0;
      applyStimulus(8'h3C, 1'b0, 1'b1);
      applyStimulus(8'hC3, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      checkOutput("t2EdgeCount", edgeQ.size(), 32);
      checkOutput("t2Spacing", badSpacing(2), 0);
      checkOutput("t2FirstEdge", edgeValQ[0], 1'b0);
      checkOutput("t2SsFalls", ssFallCount, 1);
      checkOutput("t2RxCount", rxQ.size(), 2);
      checkOutput("t2Rx0", rxQ[0], 8'h3C);
      checkOutput("t2Rx1", rxQ[1], 8'hC3);

      // Underrun: park after 0x55, then resume with 0xAA.
      clearLog();
      cpol = 1'b0; cpha = 1'b0; lsbFirst = 1'b0; ssSel = 2'd1;
      applyStimulus(8'h55, 1'b0, 1'b0);
      waitRx(1);
      repeat (20) @(negedge clk);
      checkOutput("t3Sclk", sclk, 1'b0);
      checkOutput("t3SsN", ssN, 4'b1101);
      checkOutput("t3TxReady", txReady, 1'b1);
      checkOutput("t3State", spiState, 2'b10);
      checkOutput("t3EdgesParked", edgeQ.size(), 16);
      applyStimulus(8'hAA, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      checkOutput("t3EdgeCount", edgeQ.size(), 32);
      checkOutput("t3Rx0", rxQ[0], 8'h55);
      checkOutput("t3Rx1", rxQ[1], 8'hAA);

      // clkdiv 0 with setup 3 and hold 2.
      clearLog();
      clkDiv = 8'd0; setupCyc = 4'd3; holdCyc = 4'd2; ssSel = 2'd3;
      applyStimulus(8'h3A, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      checkOutput("t4EdgeCount", edgeQ.size(), 16);
      checkOutput("t4Spacing", badSpacing(1), 0);
      checkOutput("t4Setup", edgeQ[0] - ssFallCyc, 4);
      checkOutput("t4Hold", ssRiseCyc - edgeQ[15], 3);
      checkOutput("t4Gap", readyRiseCyc - ssRiseCyc, 1);
      checkOutput("t4RxData", rxQ[0], 8'h3A);

      // Reset in the middle of 0xF0, then a clean 0x0F.
      clearLog();
      clkDiv = 8'd1; setupCyc = 4'd0; holdCyc = 4'd0; ssSel = 2'd0;
      applyStimulus(8'hF0, 1'b1, 1'b0);
      waitEdges(8);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t5SsN", ssN, 4'hF);
      checkOutput("t5State", spiState, 2'b00);
      checkOutput("t5TxReady", txReady, 1'b0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("t5NoRx", rxQ.size(), 0);
      applyStimulus(8'h0F, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      checkOutput("t5RxCount", rxQ.size(), 1);
      checkOutput("t5RxData", rxQ[0], 8'h0F);

      // Config changes mid-word apply only to the next transaction.
      clearLog();
      ssSel = 2'd2;
      applyStimulus(8'h96, 1'b1, 1'b0);
      waitEdges(5);
      cpol = 1'b1;
      clkDiv = 8'd3;
      waitIdle();
      @(negedge clk);
      checkOutput("t6EdgeCount", edgeQ.size(), 16);
      checkOutput("t6Spacing", badSpacing(2), 0);
      checkOutput("t6FirstEdge", edgeValQ[0], 1'b1);
      checkOutput("t6LastEdge", edgeValQ[15], 1'b0);
      checkOutput("t6RxData", rxQ[0], 8'h96);
      clearLog();
      applyStimulus(8'h69, 1'b1, 1'b0);
      waitIdle();
      @(negedge clk);
      checkOutput("t6bEdgeCount", edgeQ.size(), 16);
      checkOutput("t6bSpacing", badSpacing(4), 0);
      checkOutput("t6bFirstEdge", edgeValQ[0], 1'b0);
      checkOutput("t6bRxData", rxQ[0], 8'h69);
      checkOutput("t6bIdleSclk", sclk, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
Parametrised SPI master engine. Replaces the fixed 8-bit, single-select, mode-limited IO state machine. It supports:
- word widths DW bits
- NSS one-hot active-low slave selects
- all four CPOL/CPHA modes
- programmable setup and hold times
- back-to-back multi-word transfers under valid/ready handshake control

It sits between the SPI register/FIFO front end (TX words in, RX words out) and the chip pads.

Parameters:
DW, 8, bits per SPI word (legal 4..32)
SSW, 2, slave-select index width; NSS = 2**SSW select lines
CDW, 8, clock divider register width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
cpol  in  1  idle sclk level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsbfirst  in  1  bit order, applies to both TX and RX
clkdiv  in  CDW  sclk half-period = clkdiv+1 clk cycles
setup_cyc  in  4  ss-assert to first edge = setup_cyc+1 half-periods
hold_cyc  in  4  last edge to ss-deassert = hold_cyc+1 half-periods
ss_sel  in  SSW  slave index for the next transaction
tx_valid  in  1  tx word available
tx_data  in  DW  tx word
tx_last  in  1  word ends the transaction
tx_ready  out  1  engine accepts word this cycle
rx_valid  out  1  single-cycle pulse: rx_data valid
rx_data  out  DW  received word
busy  out  1  state != IDLE
spi_state  out  2  00 IDLE, 01 SETUP, 10 DATA, 11 HOLD
sclk  out  1  SPI clock
mosi  out  1  master out
ss_n  out  NSS  active-low one-hot slave selects
miso  in  1  master in (synchronous to clk at this boundary)

Behaviour:
- Reset (sync, high), effective at the next clk edge regardless of state:
  - state=IDLE, ss_n=all ones, mosi=0
  - rx_valid=0, rx_data=0, tx_ready=0
  - divider, bit and half counters = 0
  - any in-flight word is dropped; no rx_valid is emitted for it.
- tick: divider counter counts 0..clkdiv and pulses tick on wrap. One tick = one half-period. The counter is held at 0 in IDLE.
- IDLE:
  - sclk = live cpol; ss_n all ones.
  - tx_ready=1 once the inter-transaction gap (one half-period, ss_n high, after HOLD) has elapsed. It is also 1 in the first cycle after reset release.
  - On handshake, latch: tx_data, tx_last, cpol, cpha, lsbfirst, clkdiv, setup_cyc, hold_cyc, ss_sel. Then enter SETUP.
  - Later config input changes are ignored until the next IDLE accept.
- SETUP:
  - ss_n[ss_sel]=0; sclk=cpol.
  - cpha=0: mosi = first bit from entry.
  - After setup_cyc+1 ticks, enter DATA.
- DATA: each bit takes 2 half-periods. The leading edge ends half 0 (sclk goes to ~cpol); the trailing edge ends half 1 (sclk returns to cpol).
  - cpha=0: sample miso at the leading edge; mosi advances at the trailing edge.
  - cpha=1: mosi presents the next bit at the leading edge; sample miso at the trailing edge.
  - Sampling captures miso in the clk cycle whose edge updates sclk.
  - Shift direction: MSB first unless lsbfirst=1.
- Word boundary (final trailing edge of bit DW-1):
  - rx_data updated and rx_valid=1 in the following cycle.
  - If latched tx_last=1: enter HOLD.
  - Otherwise tx_ready=1 starting that cycle. If the handshake completes in that cycle, the next word's first half-period follows with no sclk gap. If tx_valid=0, pause: sclk parked at cpol, ss held, divider held at 0, tx_ready stays 1. On a later handshake, resume with a full half-period.
- HOLD:
  - sclk=cpol; ss held asserted for hold_cyc+1 ticks.
  - Then ss_n all ones and IDLE, starting the gap.
- tx_ready=0 in SETUP, HOLD and mid-word.
- Simultaneous events:
  - reset has priority over tx_valid.
  - rx_valid of the last word and the HOLD entry occur in the same cycle.
- clkdiv=0: half-period = 1 clk, so sclk = clk/2. All rules above still hold.

Test Plan:
1. DW=8, clkdiv=1, mode 0, MSB first, tx 0xA5 with tx_last=1, ss_sel=2, setup/hold=0, miso looped to mosi -> ss_n=4'b1011 throughout; 8 sclk rising edges, 4 clk apart; mosi sequence 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0xA5; ss_n=4'hF, then tx_ready after 2 clk.
2. Mode 3, lsbfirst=1, words 0x3C then 0xC3 (second tx_last=1), tx_valid held high -> 16 continuous sclk periods with no gap; ss asserted continuously; rx_valid pulses carry 0x3C then 0xC3.
3. Underrun: word 0x55 with tx_last=0, then tx_valid low for 20 clk -> sclk parked at cpol; ss_n asserted; tx_ready=1; spi_state=DATA. Sending 0xAA with tx_last=1 then resumes and completes.
4. clkdiv=0, setup_cyc=3, hold_cyc=2 -> ss fall to first sclk edge = 4 clk; last sclk edge to ss rise = 3 clk; ss high gap before next tx_ready = 1 clk.
5. Reset asserted after bit 3 of 0xF0 -> next cycle ss_n=4'hF, spi_state=0, no rx_valid. A transaction of 0x0F after release returns rx_data=0x0F.
6. Toggle cpol and clkdiv mid-word -> current transaction timing and polarity unchanged; the new values take effect only on the next transaction.
